keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x3 matrix keypad and reports one debounced key per press.
//  Output is the key_data/key_valid pair that the game-state block consumes to place marks.
//  Sits between the board I/O pins and game state; runs whenever en=1.
// PARAMETERS
//  SCAN_DIV        25000  clk cycles per column slot (1 kHz column rate at 25 MHz)
//  DEBOUNCE_FRAMES 20     consecutive identical frames required for press and for release
// PORTS
//  clk        in   1   system clock; all state on posedge clk
//  rst        in   1   asynchronous, active-high reset
//  en         in   1   scan enable; 0 freezes the scan, debounce and press state
//  key_col    out  3   column drive, one-hot active-high
//  key_row    in   4   row sense, active-high, pre-synchronised
//  key_data   out  4   code of last accepted key
//  key_valid  out  1   single-cycle strobe; key_data is valid in this cycle
//  key_busy   out  1   1 while a key is accepted and not yet released
// BEHAVIOUR
//  Reset: key_col=3'b001, key_data=0, key_valid=0, key_busy=0; div counter, frame, stable count = 0.
//  Divider: counts 0..SCAN_DIV-1 while en=1.
//   - tick=1 on the terminal count, then the counter wraps to 0.
//   - en=0 holds the counter; no ticks.
//  On tick:
//   - Sample key_row into the 4 frame bits of the current column: bit index = row*3 + col.
//   - Rotate key_col 001->010->100->001.
//   - Sampling happens before rotation, so rows settle for a full slot.
//  Frame: 12-bit snapshot, complete on the tick that samples col 2. Evaluate once per frame.
//  Keymap:
//   - row0 = 1,2,3; row1 = 4,5,6; row2 = 7,8,9; row3 = *,0,#.
//   - key_data codes: digits 0-9 = 4'd0-4'd9; '*' = 4'd10; '#' = 4'd11.
//  Debounce per frame:
//   - Frame equal to previous frame: stable_cnt++, saturating at DEBOUNCE_FRAMES.
//   - Otherwise: stable_cnt = 1.
//  IDLE (key_busy=0):
//   - Frame has exactly one bit set and stable_cnt reaches DEBOUNCE_FRAMES:
//     - the next clk pulses key_valid for 1 cycle and latches key_data;
//     - state goes to HELD (key_busy=1).
//   - Latency: 1 clk after the frame that completes the debounce count.
//  HELD:
//   - Frame all-zero and stable_cnt reaches DEBOUNCE_FRAMES: go to IDLE, key_busy=0.
//   - No further key_valid while HELD. Chords and key changes are ignored.
//  Multi-key frame (popcount>1) in IDLE: never accepted, whatever the debounce count.
//  Chord release order: a single key left after a chord must be debounced fresh before it is accepted.
//  key_data holds its value between strobes; it never changes without key_valid.
//  rst mid-scan or mid-press: immediate return to reset values; no strobe in the reset-release cycle.
//  en dropped mid-frame: partial frame kept and resumed on re-enable; no strobe while en=0.
// STRUCTURE
//  Shared package keypad_pkg:
//   - KEY_STAR=4'd10, KEY_HASH=4'd11, KEY_NONE=4'd15;
//   - N_ROWS=4, N_COLS=3;
//   - function idx_to_code(idx[3:0]) implementing the keymap.
//  Sub-module scan_tick_div (param DIV; ports clk, rst, en, tick): reused by display multiplexers.
//  Top level holds the column ring, frame register, debounce counter and the IDLE/HELD FSM.
// TESTING (SCAN_DIV=4, DEBOUNCE_FRAMES=3; behavioural keypad model drives key_row from key_col)
//  1. Reset then idle 50 frames:
//     - key_col cycles 001,010,100 every 4 clks;
//     - key_valid never 1; key_data=0.
//  2. Hold key 5 (row1,col1) for 10 frames:
//     - exactly one key_valid, key_data=4'd5, in the clk after the 3rd identical frame;
//     - key_busy=1 until release is debounced.
//  3. Press '#', bounce (toggle every 2 clks) for 2 frames, then hold:
//     - single strobe with key_data=4'd11 only after 3 clean frames.
//  4. Hold 1 and 9 together 10 frames:
//     - no strobe;
//     - release 1, keep 9: strobe key_data=4'd9 after 3 frames.
//  5. Press 7, strobe seen; press 3 while still held 7:
//     - no second strobe;
//     - release all 3 frames, press 3: strobe key_data=4'd3.
//  6. Assert rst while key 2 is 1 frame into debounce, release rst, keep key 2:
//     - outputs return to reset values;
//     - strobe key_data=4'd2 only after 3 fresh full frames.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, state type and keymap helpers for the 4x3
// matrix keypad scanner.
//   - KEY_STAR / KEY_HASH / KEY_NONE : special key codes
//   - N_ROWS / N_COLS / N_BITS       : matrix geometry (frame bit = row*3 + col)
//   - kp_state_t                     : IDLE/HELD press state
//   - idx_to_code()                  : frame bit index -> key code
//   - frame_popcount()               : number of keys set in a frame
//   - frame_first_idx()              : index of lowest set bit in a frame
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  localparam int N_ROWS = 4;
  localparam int N_COLS = 3;
  localparam int N_BITS = N_ROWS * N_COLS;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } kp_state_t;

  // Keymap: row0 = 1,2,3; row1 = 4,5,6; row2 = 7,8,9; row3 = *,0,#
  function automatic logic [3:0] idx_to_code(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd4;
      4'd4:    code = 4'd5;
      4'd5:    code = 4'd6;
      4'd6:    code = 4'd7;
      4'd7:    code = 4'd8;
      4'd8:    code = 4'd9;
      4'd9:    code = KEY_STAR;
      4'd10:   code = 4'd0;
      4'd11:   code = KEY_HASH;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] frame_popcount(input logic [N_BITS-1:0] f);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < N_BITS; i++) begin
      cnt = cnt + {3'b000, f[i]};
    end
    return cnt;
  endfunction

  // Only meaningful when exactly one bit is set; empty frame maps to KEY_NONE.
  function automatic logic [3:0] frame_first_idx(input logic [N_BITS-1:0] f);
    logic [3:0] idx;
    idx = 4'd15;
    for (int i = N_BITS - 1; i >= 0; i--) begin
      if (f[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_div.sv
// scan_tick_div: free-running divider producing a one-cycle tick every DIV
// enabled clocks. Holds its count while en=0.
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   en   in  count enable
//   tick out 1 on the terminal count (DIV-1) while en=1
module scan_tick_div #(
  parameter int DIV = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en & (r_cnt == TERM);

  // Count 0..DIV-1 while enabled, wrapping on the terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == TERM) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 matrix keypad and reports one debounced key
// per press as a key_data/key_valid strobe.
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   en        in   scan enable; 0 freezes scan, debounce and press state
//   key_col   out  [2:0] one-hot active-high column drive
//   key_row   in   [3:0] active-high row sense (already synchronised)
//   key_data  out  [3:0] code of last accepted key
//   key_valid out  single-cycle strobe qualifying key_data
//   key_busy  out  1 while an accepted key has not been released
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 25000,
  parameter int DEBOUNCE_FRAMES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [2:0] key_col,
  input  logic [3:0] key_row,
  output logic [3:0] key_data,
  output logic       key_valid,
  output logic       key_busy
);

  localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SW-1:0] DEB_MAX = SW'(DEBOUNCE_FRAMES);

  logic              w_tick;
  logic              w_frame_end;
  logic [1:0]        w_col_idx;
  logic [N_BITS-1:0] w_frame;
  logic [SW-1:0]     w_stable_next;

  logic [2:0]        r_col;
  logic [N_BITS-1:0] r_frame;       // frame under assembly
  logic [N_BITS-1:0] r_last;        // last complete frame
  logic [SW-1:0]     r_stable;
  logic              r_frame_done;  // a new complete frame awaits evaluation
  kp_state_t         r_state;

  scan_tick_div #(
    .DIV (SCAN_DIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (w_tick)
  );

  assign key_col     = r_col;
  // The tick that samples column 2 completes the frame
  assign w_frame_end = w_tick & r_col[2];

  // Decode the one-hot column ring to a column index
  always_comb begin
    case (r_col)
      3'b001:  w_col_idx = 2'd0;
      3'b010:  w_col_idx = 2'd1;
      3'b100:  w_col_idx = 2'd2;
      default: w_col_idx = 2'd0;
    endcase
  end

  // Current frame with the active column's rows merged in
  always_comb begin
    w_frame = r_frame;
    for (int r = 0; r < N_ROWS; r++) begin
      w_frame[r * N_COLS + int'(w_col_idx)] = key_row[r];
    end
  end

  // Saturating stability count for the frame being completed
  always_comb begin
    if (w_frame == r_last) begin
      if (r_stable == DEB_MAX) begin
        w_stable_next = r_stable;
      end else begin
        w_stable_next = r_stable + SW'(1);
      end
    end else begin
      w_stable_next = SW'(1);
    end
  end

  // Column ring, frame assembly and debounce counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col        <= 3'b001;
      r_frame      <= '0;
      r_last       <= '0;
      r_stable     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      // Sample before rotating so the rows have settled for a full slot
      if (w_tick) begin
        r_frame <= w_frame;
        r_col   <= {r_col[1:0], r_col[2]};
      end
      if (w_frame_end) begin
        r_last       <= w_frame;
        r_stable     <= w_stable_next;
        r_frame_done <= 1'b1;
      end else if (en) begin
        // Kept pending across en=0 so evaluation resumes on re-enable
        r_frame_done <= 1'b0;
      end
    end
  end

  // IDLE/HELD press FSM with registered outputs, evaluated once per frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      key_valid <= 1'b0;
      key_data  <= 4'd0;
      key_busy  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (en && r_frame_done) begin
        case (r_state)
          ST_IDLE: begin
            // Chords (popcount > 1) are never accepted
            if ((r_stable == DEB_MAX) && (frame_popcount(r_last) == 4'd1)) begin
              key_valid <= 1'b1;
              key_data  <= idx_to_code(frame_first_idx(r_last));
              key_busy  <= 1'b1;
              r_state   <= ST_HELD;
            end
          end
          ST_HELD: begin
            if ((r_stable == DEB_MAX) && (r_last == '0)) begin
              key_busy <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end
          default: begin
            key_busy <= 1'b0;
            r_state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4 and
// DEBOUNCE_FRAMES=3. A keypad model drives key_row from key_col and the set
// of pressed keys (bit = row*3 + col). en_cnt counts enabled clock edges
// since reset; a frame completes on every edge where en_cnt is a multiple
// of 12 and an accepted key strobes one edge after its 3rd stable frame.
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  key_col;
  logic [3:0]  key_row;
  logic [3:0]  key_data;
  logic        key_valid;
  logic        key_busy;

  logic [11:0] pressed;
  int          en_cnt;
  int          strobe_cnt;
  int          errors;
  int          checks;

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .key_col   (key_col),
    .key_row   (key_row),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_busy  (key_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a row reads high when a pressed key sits on the driven column
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      key_row[r] = |(pressed[r*3 +: 3] & key_col);
    end
  end

  // Enabled-edge counter and strobe counter
  always @(posedge clk) begin
    if (rst) begin
      en_cnt <= 0;
    end else if (en) begin
      en_cnt <= en_cnt + 1;
    end
    if (key_valid) begin
      strobe_cnt <= strobe_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (en_cnt=%0d)", tag, obs, exp, en_cnt);
    end
  endtask

  task automatic step_to(input int t);
    int guard = 0;
    while (en_cnt != t && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("step_to", 32'(en_cnt), 32'(t));
  endtask

  task automatic sync_frame();
    int guard = 0;
    while ((en_cnt % 12) != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("sync_frame", 32'(en_cnt % 12), 32'd0);
  endtask

  task automatic release_all();
    int b;
    sync_frame();
    b = en_cnt;
    pressed = 12'h000;
    step_to(b + 48);
    chk("release_busy", 32'(key_busy), 32'd0);
  endtask

  function automatic logic [2:0] exp_col(input int n);
    logic [2:0] one;
    one = 3'b001;
    return one << ((n / 4) % 3);
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int s0;
    errors     = 0;
    checks     = 0;
    strobe_cnt = 0;
    pressed    = 12'h000;
    en         = 1'b1;
    rst        = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_col",   32'(key_col),   32'd1);
    chk("rst_data",  32'(key_data),  32'd0);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_busy",  32'(key_busy),  32'd0);
    rst = 1'b0;

    // 1. Idle 50 frames: column rotation every 4 clocks, no strobes
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      chk("idle_col", 32'(key_col), 32'(exp_col(en_cnt)));
      chk("idle_valid", 32'(key_valid), 32'd0);
    end
    chk("idle_data", 32'(key_data), 32'd0);
    chk("idle_strobes", 32'(strobe_cnt), 32'd0);

    // 2. Hold key 5 for 10 frames, then release
    sync_frame();
    base = en_cnt;
    s0 = strobe_cnt;
    pressed = 12'h010;
    step_to(base + 36);
    chk("k5_early_valid", 32'(key_valid), 32'd0);
    chk("k5_early_busy",  32'(key_busy),  32'd0);
    step_to(base + 37);
    chk("k5_valid", 32'(key_valid), 32'd1);
    chk("k5_data",  32'(key_data),  32'd5);
    chk("k5_busy",  32'(key_busy),  32'd1);
    step_to(base + 38);
    chk("k5_pulse_end", 32'(key_valid), 32'd0);
    step_to(base + 120);
    chk("k5_one_strobe", 32'(strobe_cnt), 32'(s0 + 1));
    chk("k5_held_busy",  32'(key_busy),   32'd1);
    pressed = 12'h000;
    step_to(base + 156);
    chk("k5_rel_busy_hold", 32'(key_busy), 32'd1);
    step_to(base + 157);
    chk("k5_rel_busy", 32'(key_busy), 32'd0);
    chk("k5_data_kept", 32'(key_data), 32'd5);

    // 3. '#' bouncing every 2 clocks for 2 frames, then held
    sync_frame();
    base = en_cnt;
    s0 = strobe_cnt;
    for (int k = 0; k < 12; k++) begin
      pressed = (k % 2 == 0) ? 12'h800 : 12'h000;
      repeat (2) @(negedge clk);
    end
    pressed = 12'h800;
    step_to(base + 60);
    chk("hash_early_valid", 32'(key_valid),  32'd0);
    chk("hash_no_strobe",   32'(strobe_cnt), 32'(s0));
    step_to(base + 61);
    chk("hash_valid", 32'(key_valid), 32'd1);
    chk("hash_data",  32'(key_data),  32'd11);
    release_all();
    chk("hash_one_strobe", 32'(strobe_cnt), 32'(s0 + 1));

    // 4. Chord 1+9 held, then 1 released leaving 9
    sync_frame();
    base = en_cnt;
    s0 = strobe_cnt;
    pressed = 12'h101;
    step_to(base + 120);
    chk("chord_no_strobe", 32'(strobe_cnt), 32'(s0));
    chk("chord_busy",      32'(key_busy),   32'd0);
    pressed = 12'h100;
    step_to(base + 156);
    chk("k9_early_valid", 32'(key_valid), 32'd0);
    step_to(base + 157);
    chk("k9_valid", 32'(key_valid), 32'd1);
    chk("k9_data",  32'(key_data),  32'd9);
    release_all();

    // 5. Key 7 accepted, 3 added while held, all released, then 3
    sync_frame();
    base = en_cnt;
    s0 = strobe_cnt;
    pressed = 12'h040;
    step_to(base + 37);
    chk("k7_valid", 32'(key_valid), 32'd1);
    chk("k7_data",  32'(key_data),  32'd7);
    step_to(base + 48);
    pressed = 12'h044;
    step_to(base + 108);
    chk("k7k3_one_strobe", 32'(strobe_cnt), 32'(s0 + 1));
    chk("k7k3_data",       32'(key_data),   32'd7);
    chk("k7k3_busy",       32'(key_busy),   32'd1);
    pressed = 12'h000;
    step_to(base + 145);
    chk("k7_rel_busy", 32'(key_busy), 32'd0);
    step_to(base + 156);
    pressed = 12'h004;
    step_to(base + 192);
    chk("k3_early_valid", 32'(key_valid), 32'd0);
    step_to(base + 193);
    chk("k3_valid", 32'(key_valid), 32'd1);
    chk("k3_data",  32'(key_data),  32'd3);
    step_to(base + 194);
    chk("k3_strobes", 32'(strobe_cnt), 32'(s0 + 2));
    release_all();

    // 6. Reset while key 2 is one frame into debounce
    sync_frame();
    base = en_cnt;
    pressed = 12'h002;
    step_to(base + 18);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_col",   32'(key_col),   32'd1);
    chk("mid_rst_data",  32'(key_data),  32'd0);
    chk("mid_rst_valid", 32'(key_valid), 32'd0);
    chk("mid_rst_busy",  32'(key_busy),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = strobe_cnt;
    step_to(1);
    chk("k2_release_valid", 32'(key_valid), 32'd0);
    step_to(36);
    chk("k2_early_valid", 32'(key_valid),  32'd0);
    chk("k2_no_strobe",   32'(strobe_cnt), 32'(s0));
    step_to(37);
    chk("k2_valid", 32'(key_valid), 32'd1);
    chk("k2_data",  32'(key_data),  32'd2);
    chk("k2_busy",  32'(key_busy),  32'd1);

    // 7. en dropped mid-frame: scan frozen, key released while disabled
    step_to(42);
    en = 1'b0;
    s0 = strobe_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) pressed = 12'h000;
      chk("en0_col",   32'(key_col),   32'(exp_col(42)));
      chk("en0_valid", 32'(key_valid), 32'd0);
    end
    chk("en0_busy", 32'(key_busy), 32'd1);
    en = 1'b1;
    step_to(50);
    chk("en1_col", 32'(key_col), 32'(exp_col(50)));
    step_to(102);
    chk("en1_busy",    32'(key_busy),   32'd0);
    chk("en1_data",    32'(key_data),   32'd2);
    chk("en1_strobes", 32'(strobe_cnt), 32'(s0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
